// File: rtl/mem_test_pkg.sv
// Shared types for the March C- memory test engine: FSM states, element index and per-element op table.
package mem_test_pkg;

    localparam int NUM_ELEM = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [2:0] elem_idx_t;

    typedef struct packed {
        logic dir_down;
        logic has_rd;
        logic rd_val;
        logic has_wr;
        logic wr_val;
    } elem_attr_t;

    // {dir_down, has_rd, rd_val, has_wr, wr_val}; indices past E5 are never issued.
    function automatic elem_attr_t elem_attr(input elem_idx_t e);
        case (e)
            3'd0:    return elem_attr_t'(5'b0_0_0_1_0);
            3'd1:    return elem_attr_t'(5'b0_1_0_1_1);
            3'd2:    return elem_attr_t'(5'b0_1_1_1_0);
            3'd3:    return elem_attr_t'(5'b1_1_0_1_1);
            3'd4:    return elem_attr_t'(5'b1_1_1_1_0);
            3'd5:    return elem_attr_t'(5'b0_1_0_0_0);
            default: return elem_attr_t'(5'b0_0_0_0_0);
        endcase
    endfunction

endpackage

// File: rtl/mem_test_march_if.sv
// Simple synchronous memory port: one op per cycle, read data returns one cycle after mem_re.
interface mem_test_march_if #(
    parameter int AW = 4,
    parameter int DW = 8
);
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;

    modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
    modport slave  (input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/mem_test_cmp.sv
// Read-beat compare stage: registers expected value/address one cycle behind each read, sticky first-fail capture.
// Optional saturating error counter built only when MEM_TEST_ERRCNT_EN is defined; no backpressure.
module mem_test_cmp #(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clr_i,
    input  logic          rd_vld_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic [DW-1:0] rd_exp_i,
    input  logic [DW-1:0] rd_dat_i,
    output logic          fail_o,
    output logic [AW-1:0] fail_addr_o,
    output logic [DW-1:0] fail_data_o,
    output logic [7:0]    err_count_o
);
    logic          exp_vld_q;
    logic [DW-1:0] exp_q;
    logic [AW-1:0] exp_addr_q;
    logic          fail_q, fail_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [DW-1:0] fail_data_q, fail_data_d;
    logic          mismatch;

    assign mismatch = exp_vld_q && (rd_dat_i != exp_q);

    always_comb begin
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        if (clr_i) begin
            fail_d      = 1'b0;
            fail_addr_d = '0;
            fail_data_d = '0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            if (!fail_q) begin
                fail_addr_d = exp_addr_q;
                fail_data_d = rd_dat_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exp_vld_q   <= 1'b0;
            exp_q       <= '0;
            exp_addr_q  <= '0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            exp_vld_q   <= rd_vld_i;
            exp_q       <= rd_exp_i;
            exp_addr_q  <= rd_addr_i;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;

`ifdef MEM_TEST_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_i) begin
            err_cnt_d = '0;
        end else if (mismatch && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count_o = err_cnt_q;
`else
    assign err_count_o = '0;
`endif

endmodule

// File: rtl/mem_test_march.sv
// March C- test engine (optional error counter: MEM_TEST_ERRCNT_EN); first op one cycle after start, busy 10*DEPTH+1 cycles.
// Drives the memory port every RUN cycle with no backpressure; start is ignored while busy.
module mem_test_march
    import mem_test_pkg::*;
#(
    parameter int AW = 4,
    parameter int DW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    mem_test_march_if.master mem,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             fail,
    output logic [AW-1:0]    fail_addr,
    output logic [DW-1:0]    fail_data,
    output logic [7:0]       err_count
);
    localparam logic [AW-1:0] ADDR_LAST = '1;

    state_e        state_q, state_d;
    elem_idx_t     elem_q, elem_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          phase_q, phase_d;    // 0: read op, 1: write op
    logic [DW-1:0] wdata_q, wdata_d;

    elem_attr_t    cur_attr, nxt_attr, first_attr;
    logic          last_addr;
    logic          run_start;

    assign cur_attr   = elem_attr(elem_q);
    assign nxt_attr   = elem_attr(elem_q + 3'd1);
    assign first_attr = elem_attr('0);
    assign last_addr  = cur_attr.dir_down ? (addr_q == '0) : (addr_q == ADDR_LAST);
    assign run_start  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            elem_q  <= '0;
            addr_q  <= '0;
            phase_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        elem_d  = elem_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (run_start) begin
                    state_d = ST_RUN;
                    elem_d  = '0;
                    addr_d  = first_attr.dir_down ? ADDR_LAST : '0;
                    phase_d = ~first_attr.has_rd;
                    wdata_d = {DW{first_attr.wr_val}};
                end
            end
            ST_RUN: begin
                if (!phase_q && cur_attr.has_wr) begin
                    phase_d = 1'b1;
                end else if (!last_addr) begin
                    addr_d  = cur_attr.dir_down ? (addr_q - 1'b1) : (addr_q + 1'b1);
                    phase_d = ~cur_attr.has_rd;
                end else if (elem_q == elem_idx_t'(NUM_ELEM - 1)) begin
                    state_d = ST_DRAIN;
                end else begin
                    // Wrap straight into the next element with no bubble.
                    elem_d  = elem_q + 3'd1;
                    addr_d  = nxt_attr.dir_down ? ADDR_LAST : '0;
                    phase_d = ~nxt_attr.has_rd;
                    if (nxt_attr.has_wr) begin
                        wdata_d = {DW{nxt_attr.wr_val}};
                    end
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy          = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_re    = 1'b0;
        mem.mem_addr  = addr_q;
        mem.mem_wdata = wdata_q;
        case (state_q)
            ST_RUN: begin
                busy       = 1'b1;
                mem.mem_we = phase_q;
                mem.mem_re = ~phase_q;
            end
            ST_DRAIN: busy = 1'b1;
            default: ;
        endcase
        done = (state_q == ST_DONE);
        pass = done & ~fail;
    end

    mem_test_cmp #(
        .AW(AW),
        .DW(DW)
    ) u_cmp (
        .clk_i      (clk),
        .rst_i      (rst),
        .clr_i      (run_start),
        .rd_vld_i   (mem.mem_re),
        .rd_addr_i  (addr_q),
        .rd_exp_i   ({DW{cur_attr.rd_val}}),
        .rd_dat_i   (mem.mem_rdata),
        .fail_o     (fail),
        .fail_addr_o(fail_addr),
        .fail_data_o(fail_data),
        .err_count_o(err_count)
    );

endmodule

// File: tb/tb_mem_test_march.sv
// Bench for mem_test_march at AW=2: expected op trace queued per run, compared as strobes appear.
module tb_mem_test_march;
    localparam int AW    = 2;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;
`ifdef MEM_TEST_ERRCNT_EN
    localparam logic [7:0] ERR_STUCK = 8'd3;
`else
    localparam logic [7:0] ERR_STUCK = 8'd0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, pass, fail;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic [7:0]    err_count;

    mem_test_march_if #(.AW(AW), .DW(DW)) mif ();

    mem_test_march #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mem      (mif),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .fail     (fail),
        .fail_addr(fail_addr),
        .fail_data(fail_data),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    // Memory model; stuck_en forces bit 0 of address 2 to read as 1.
    logic [DW-1:0] mem_model [DEPTH];
    logic          stuck_en;

    always @(posedge clk) begin
        if (mif.mem_we) mem_model[mif.mem_addr] <= mif.mem_wdata;
        if (mif.mem_re) mif.mem_rdata <= mem_model[mif.mem_addr] |
                                         ((stuck_en && mif.mem_addr == 2'd2) ? 8'h01 : 8'h00);
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    logic [31:0] exp_q [$];

    function automatic logic [31:0] op_word(input bit we, input bit re, input int a, input logic [7:0] wd);
        return {20'd0, we, re, AW'(a), wd};
    endfunction

    task automatic build_trace();
        int wv [6] = '{0, 1, 0, 1, 0, 0};
        int a;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < DEPTH; i++) begin
                a = (e == 3 || e == 4) ? DEPTH - 1 - i : i;
                if (e != 0) exp_q.push_back(op_word(1'b0, 1'b1, a, 8'h00));
                if (e != 5) exp_q.push_back(op_word(1'b1, 1'b0, a, (wv[e] != 0) ? 8'hFF : 8'h00));
            end
        end
    endtask

    bit          mon_en = 1'b0;
    int          busy_cnt, strobe_cnt, gap_cnt, last_op_cyc;
    int          cyc_now = 0;
    logic [31:0] mon_act;

    always @(negedge clk) begin
        cyc_now++;
        if (mon_en) begin
            if (busy) busy_cnt++;
            if (mif.mem_we || mif.mem_re) begin
                strobe_cnt++;
                if (last_op_cyc >= 0 && cyc_now != last_op_cyc + 1) gap_cnt++;
                last_op_cyc = cyc_now;
                mon_act = {20'd0, mif.mem_we, mif.mem_re, mif.mem_addr,
                           mif.mem_we ? mif.mem_wdata : 8'h00};
                if (exp_q.size() == 0) check("op_extra", mon_act, 32'hFFFF_FFFF);
                else check($sformatf("op%0d", strobe_cnt), mon_act, exp_q.pop_front());
            end
        end
    end

    task automatic run_chk(input string tag, input bit stuck, input bit repulse, input bit exp_fail,
                           input logic [AW-1:0] exp_faddr, input logic [DW-1:0] exp_fdata,
                           input logic [7:0] exp_err);
        int cyc;
        stuck_en = stuck;
        exp_q.delete();
        build_trace();
        busy_cnt    = 0;
        strobe_cnt  = 0;
        gap_cnt     = 0;
        last_op_cyc = -1;
        mon_en      = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy_rise"}, 32'(busy), 32'd1);
        check({tag, "_fail_clr"}, 32'(fail), 32'd0);
        cyc = 1;
        while (!done && cyc < 500) begin
            @(negedge clk);
            cyc++;
            start = repulse && (cyc == 10 || cyc == 30);
        end
        start = 1'b0;
        check({tag, "_done_seen"}, 32'(done), 32'd1);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(10 * DEPTH + 1));
        check({tag, "_strobes"}, 32'(strobe_cnt), 32'(10 * DEPTH));
        check({tag, "_gaps"}, 32'(gap_cnt), 32'd0);
        check({tag, "_ops_left"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'(!exp_fail));
        check({tag, "_fail"}, 32'(fail), 32'(exp_fail));
        check({tag, "_fail_addr"}, 32'(fail_addr), 32'(exp_faddr));
        check({tag, "_fail_data"}, 32'(fail_data), 32'(exp_fdata));
        check({tag, "_err_count"}, 32'(err_count), 32'(exp_err));
        repeat (2) @(negedge clk);
        check({tag, "_done_hold"}, 32'(done), 32'd1);
        mon_en = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_pass"}, 32'(pass), 32'd0);
        check({tag, "_fail"}, 32'(fail), 32'd0);
        check({tag, "_we"}, 32'(mif.mem_we), 32'd0);
        check({tag, "_re"}, 32'(mif.mem_re), 32'd0);
        check({tag, "_addr"}, 32'(mif.mem_addr), 32'd0);
        check({tag, "_wdata"}, 32'(mif.mem_wdata), 32'd0);
        check({tag, "_fail_addr"}, 32'(fail_addr), 32'd0);
        check({tag, "_fail_data"}, 32'(fail_data), 32'd0);
        check({tag, "_err_count"}, 32'(err_count), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stuck_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;
        @(negedge clk);

        run_chk("good", 1'b0, 1'b0, 1'b0, '0, '0, 8'd0);
        run_chk("stuck", 1'b1, 1'b0, 1'b1, 2'd2, 8'h01, ERR_STUCK);
        run_chk("rerun", 1'b0, 1'b0, 1'b0, '0, '0, 8'd0);
        run_chk("repulse", 1'b0, 1'b1, 1'b0, '0, '0, 8'd0);

        // Abort a failing run at cycle 20, after the E1 mismatch has been captured.
        stuck_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        check("abort_pre_fail", 32'(fail), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("abort");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_chk("post_abort", 1'b0, 1'b0, 1'b0, '0, '0, 8'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
